// File: rtl/iomem_arb_pkg.sv
// Shared definitions for the two-master iomem arbiter.
//   state_t                 : arbiter FSM encoding (IDLE / BUSY)
//   DEFAULT_TIMEOUT_CYCLES  : default BUSY cycles allowed without s_ready
//   DEFAULT_ERR_RDATA       : default read data returned on a timeout
//   CTR_W                   : width of the timeout counter
package iomem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;
    localparam logic [31:0] DEFAULT_ERR_RDATA      = 32'hFFFF_FFFF;
    localparam int          CTR_W                  = 16;

endpackage

// File: rtl/iomem_timeout_ctr.sv
// Timeout counter for the iomem arbiter.
// Counts BUSY cycles in which the slave has not answered.
//   clk, resetn : clock, asynchronous active-low reset
//   clear       : synchronous clear (held while the arbiter is idle so the
//                 count starts at zero on BUSY entry)
//   enable      : count this cycle
//   tc          : terminal count, high while the count equals LIMIT
module iomem_timeout_ctr
    import iomem_arb_pkg::*;
#(
    parameter int unsigned LIMIT = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [CTR_W-1:0] LIMIT_VAL = CTR_W'(LIMIT);

    logic [CTR_W-1:0] count_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign tc = (count_reg == LIMIT_VAL);

endmodule

// File: rtl/iomem_arbiter.sv
// Round-robin arbiter sharing one iomem slave port between two masters
// (m0 = CPU, m1 = accelerator), with a bus-timeout watchdog.
//   clk, resetn          : clock, asynchronous active-low reset
//   m0_* / m1_*          : master iomem ports (valid/ready/wstrb/addr/wdata/rdata)
//   s_*                  : shared slave iomem port
//   err_clear            : clears the sticky timeout flag
//   err_timeout          : sticky flag, set when a transaction timed out
//   err_addr             : address of the most recent timed-out transaction
//   grant                : index of the master currently or last granted
module iomem_arbiter
    import iomem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter logic [31:0] ERR_RDATA      = DEFAULT_ERR_RDATA
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        err_clear,
    output logic        err_timeout,
    output logic [31:0] err_addr,
    output logic        grant
);

    state_t      state_reg, state_next;
    logic        grant_reg, grant_next;
    logic        last_grant_reg, last_grant_next;
    logic        err_timeout_reg, err_timeout_next;
    logic [31:0] err_addr_reg, err_addr_next;

    // Request of whichever master holds the grant.
    logic        g_valid;
    logic [3:0]  g_wstrb;
    logic [31:0] g_addr;
    logic [31:0] g_wdata;

    logic        tc;
    logic        done;
    logic [31:0] resp_data;

    assign g_valid = grant_reg ? m1_valid : m0_valid;
    assign g_wstrb = grant_reg ? m1_wstrb : m0_wstrb;
    assign g_addr  = grant_reg ? m1_addr  : m0_addr;
    assign g_wdata = grant_reg ? m1_wdata : m0_wdata;

    iomem_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk    (clk),
        .resetn (resetn),
        .clear  (state_reg == IDLE),
        .enable ((state_reg == BUSY) && g_valid && !s_ready && !tc),
        .tc     (tc)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg       <= IDLE;
            grant_reg       <= 1'b0;
            last_grant_reg  <= 1'b1;
            err_timeout_reg <= 1'b0;
            err_addr_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            grant_reg       <= grant_next;
            last_grant_reg  <= last_grant_next;
            err_timeout_reg <= err_timeout_next;
            err_addr_reg    <= err_addr_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        // A clear is applied first so that a timeout in the same cycle wins.
        err_timeout_next = err_clear ? 1'b0 : err_timeout_reg;
        err_addr_next    = err_addr_reg;
        s_valid   = 1'b0;
        s_wstrb   = g_wstrb;
        s_addr    = g_addr;
        s_wdata   = g_wdata;
        m0_ready  = 1'b0;
        m1_ready  = 1'b0;
        m0_rdata  = '0;
        m1_rdata  = '0;
        done      = 1'b0;
        resp_data = tc ? ERR_RDATA : s_rdata;

        case (state_reg)
            IDLE: begin
                // s_ready is deliberately ignored here: a late response
                // belongs to a transaction that has already been closed.
                if (m0_valid || m1_valid) begin
                    grant_next = (m0_valid && m1_valid) ? ~last_grant_reg : m1_valid;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (!g_valid) begin
                    // Master abandoned its request: close quietly and keep
                    // the round-robin pointer where it was.
                    state_next = IDLE;
                end else begin
                    // On timeout the slave request is withdrawn in the same
                    // cycle the master is answered with the error word.
                    s_valid = !tc;
                    done    = tc || s_ready;
                    if (grant_reg) begin
                        m1_ready = done;
                        m1_rdata = resp_data;
                    end else begin
                        m0_ready = done;
                        m0_rdata = resp_data;
                    end
                    if (done) begin
                        // A timed-out transaction counts as served for
                        // round-robin purposes.
                        state_next      = IDLE;
                        last_grant_next = grant_reg;
                    end
                    if (tc) begin
                        err_timeout_next = 1'b1;
                        err_addr_next    = g_addr;
                    end
                end
            end
        endcase
    end

    assign err_timeout = err_timeout_reg;
    assign err_addr    = err_addr_reg;
    assign grant       = grant_reg;

endmodule

// File: tb/tb_iomem_arbiter.sv
// Self-checking bench for iomem_arbiter: directed scenarios plus a
// randomized two-master / variable-latency-slave run against a
// transaction-level round-robin reference model.
module tb_iomem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_valid, m0_ready;
    logic [3:0]  m0_wstrb;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_valid, m1_ready;
    logic [3:0]  m1_wstrb;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        s_valid, s_ready;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        err_clear, err_timeout;
    logic [31:0] err_addr;
    logic        grant;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    iomem_arbiter #(
        .TIMEOUT_CYCLES (8),
        .ERR_RDATA      (32'hFFFF_FFFF)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .m0_valid    (m0_valid),
        .m0_ready    (m0_ready),
        .m0_wstrb    (m0_wstrb),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_rdata    (m0_rdata),
        .m1_valid    (m1_valid),
        .m1_ready    (m1_ready),
        .m1_wstrb    (m1_wstrb),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_rdata    (m1_rdata),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_wstrb     (s_wstrb),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_rdata     (s_rdata),
        .err_clear   (err_clear),
        .err_timeout (err_timeout),
        .err_addr    (err_addr),
        .grant       (grant)
    );

    task automatic idle_inputs();
        m0_valid = 1'b0; m0_wstrb = 4'h0; m0_addr = '0; m0_wdata = '0;
        m1_valid = 1'b0; m1_wstrb = 4'h0; m1_addr = '0; m1_wdata = '0;
        s_ready  = 1'b0; s_rdata  = '0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; err_clear = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        m0_valid = 1'b1; m1_valid = 1'b1; s_ready = 1'b1;
        #1;
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_s_valid: got %b expected 0", s_valid); end
        checks++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b%b expected 00", m0_ready, m1_ready); end
        checks++; if (grant !== 1'b0) begin errors++; $display("FAIL reset_grant: got %b expected 0", grant); end
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err_timeout: got %b expected 0", err_timeout); end
        checks++; if (err_addr !== 32'h0) begin errors++; $display("FAIL reset_err_addr: got %h expected 0", err_addr); end
        idle_inputs();
        resetn = 1'b1;
        @(negedge clk);
    endtask

    // Both masters request continuously: service must start with m0 right
    // after reset and then alternate.
    task automatic test_tie();
        logic [31:0] a0, a1;
        int exp;
        resetn = 1'b0;
        idle_inputs();
        @(negedge clk);
        resetn = 1'b1;
        a0 = 32'h0300_0100; a1 = 32'h0300_0200;
        m0_valid = 1'b1; m0_addr = a0; m0_wstrb = 4'hF; m0_wdata = 32'h11;
        m1_valid = 1'b1; m1_addr = a1; m1_wstrb = 4'hF; m1_wdata = 32'h22;
        s_ready = 1'b1; s_rdata = 32'h5555_AAAA;
        for (int k = 0; k < 6; k++) begin
            exp = k % 2;
            #1;
            checks++; if (s_valid !== 1'b0 || m0_ready !== 1'b0 || m1_ready !== 1'b0) begin
                errors++; $display("FAIL tie_idle_%0d: got s_valid=%b ready=%b%b expected all 0", k, s_valid, m0_ready, m1_ready);
            end
            @(negedge clk); #1;
            checks++; if (grant !== exp[0]) begin errors++; $display("FAIL tie_grant_%0d: got %b expected %0d", k, grant, exp); end
            checks++; if (s_addr !== (exp == 1 ? a1 : a0)) begin errors++; $display("FAIL tie_addr_%0d: got %h expected %h", k, s_addr, (exp == 1 ? a1 : a0)); end
            checks++; if (m0_ready !== (exp == 0) || m1_ready !== (exp == 1)) begin
                errors++; $display("FAIL tie_ready_%0d: got %b%b (m1,m0) expected m%0d only", k, m1_ready, m0_ready, exp);
            end
            $display("txn tie %0d: m%0d addr=%h", k, exp, s_addr);
            @(negedge clk);
            if (exp == 0) begin a0 = a0 + 4; m0_addr = a0; end
            else          begin a1 = a1 + 4; m1_addr = a1; end
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_write();
        m0_valid = 1'b1; m0_addr = 32'h0300_0000; m0_wdata = 32'h0000_00A5; m0_wstrb = 4'hF;
        s_ready = 1'b0;
        #1;
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL wr_cycle0_s_valid: got %b expected 0", s_valid); end
        @(negedge clk); #1;
        checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL wr_s_valid: got %b expected 1", s_valid); end
        checks++; if (s_addr !== 32'h0300_0000 || s_wdata !== 32'h0000_00A5 || s_wstrb !== 4'hF) begin
            errors++; $display("FAIL wr_payload: got %h/%h/%h expected 03000000/000000a5/f", s_addr, s_wdata, s_wstrb);
        end
        checks++; if (m0_ready !== 1'b0) begin errors++; $display("FAIL wr_early_ready: got %b expected 0", m0_ready); end
        @(negedge clk);
        s_ready = 1'b1;
        #1;
        checks++; if (m0_ready !== 1'b1 || m1_ready !== 1'b0) begin errors++; $display("FAIL wr_ready: got m0=%b m1=%b expected 1/0", m0_ready, m1_ready); end
        $display("txn write: m0 addr=%h wdata=%h", s_addr, s_wdata);
        @(negedge clk);
        m0_valid = 1'b0; s_ready = 1'b0;
        #1;
        checks++; if (m0_ready !== 1'b0 || s_valid !== 1'b0) begin errors++; $display("FAIL wr_after: got ready=%b s_valid=%b expected 0/0", m0_ready, s_valid); end
        @(negedge clk);
    endtask

    task automatic test_read();
        m1_valid = 1'b1; m1_addr = 32'h0300_0000; m1_wstrb = 4'h0; m1_wdata = '0;
        #1;
        @(negedge clk);
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        #1;
        checks++; if (m1_ready !== 1'b1 || m1_rdata !== 32'h1234_5678) begin
            errors++; $display("FAIL rd_data: got ready=%b rdata=%h expected 1/12345678", m1_ready, m1_rdata);
        end
        checks++; if (m0_rdata !== 32'h0 || m0_ready !== 1'b0) begin errors++; $display("FAIL rd_other: got m0 rdata=%h ready=%b expected 0/0", m0_rdata, m0_ready); end
        checks++; if (s_wstrb !== 4'h0 || grant !== 1'b1) begin errors++; $display("FAIL rd_wstrb_grant: got %h/%b expected 0/1", s_wstrb, grant); end
        $display("txn read: m1 addr=%h rdata=%h", s_addr, m1_rdata);
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (m1_ready !== 1'b0 || m1_rdata !== 32'h0) begin errors++; $display("FAIL rd_after: got %b/%h expected 0/0", m1_ready, m1_rdata); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int bad;
        m0_valid = 1'b1; m0_addr = 32'h0400_0010; m0_wstrb = 4'h0;
        s_ready = 1'b0;
        #1;
        bad = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk); #1;
            if (s_valid !== 1'b1 || m0_ready !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL to_wait: got %0d bad cycles expected 0", bad); end
        @(negedge clk); #1;
        checks++; if (m0_ready !== 1'b1 || m0_rdata !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL to_resp: got ready=%b rdata=%h expected 1/ffffffff", m0_ready, m0_rdata);
        end
        checks++; if (s_valid !== 1'b0 || m1_ready !== 1'b0) begin errors++; $display("FAIL to_s_valid: got %b/%b expected 0/0", s_valid, m1_ready); end
        $display("txn timeout: m0 addr=%h rdata=%h", m0_addr, m0_rdata);
        @(negedge clk);
        m0_valid = 1'b0; s_ready = 1'b1; s_rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (err_timeout !== 1'b1 || err_addr !== 32'h0400_0010) begin
            errors++; $display("FAIL to_err: got %b/%h expected 1/04000010", err_timeout, err_addr);
        end
        checks++; if (m0_ready !== 1'b0 || m0_rdata !== 32'h0) begin errors++; $display("FAIL to_late: got %b/%h expected 0/0", m0_ready, m0_rdata); end
        @(negedge clk); #1;
        checks++; if (s_valid !== 1'b0 || m0_ready !== 1'b0) begin errors++; $display("FAIL to_late2: got %b/%b expected 0/0", s_valid, m0_ready); end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        m1_valid = 1'b1; m1_addr = 32'h0300_0040; m1_wstrb = 4'h3; m1_wdata = 32'hCAFE;
        #1;
        @(negedge clk); #1;
        checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL rm_busy: got %b expected 1", s_valid); end
        #2;
        resetn = 1'b0; s_ready = 1'b1;
        #1;
        checks++; if (s_valid !== 1'b0 || m0_ready !== 1'b0 || m1_ready !== 1'b0) begin
            errors++; $display("FAIL rm_outputs: got s_valid=%b ready=%b%b expected 0/00", s_valid, m0_ready, m1_ready);
        end
        checks++; if (err_timeout !== 1'b0 || err_addr !== 32'h0 || grant !== 1'b0) begin
            errors++; $display("FAIL rm_state: got %b/%h/%b expected 0/0/0", err_timeout, err_addr, grant);
        end
        @(negedge clk);
        resetn = 1'b1; s_ready = 1'b0;
        m0_valid = 1'b1; m0_addr = 32'h0300_0080; m0_wstrb = 4'hF; m0_wdata = 32'h1;
        #1;
        @(negedge clk); #1;
        checks++; if (grant !== 1'b0 || s_addr !== 32'h0300_0080 || s_valid !== 1'b1) begin
            errors++; $display("FAIL rm_rearb: got grant=%b addr=%h valid=%b expected 0/03000080/1", grant, s_addr, s_valid);
        end
        s_ready = 1'b1;
        #1;
        checks++; if (m0_ready !== 1'b1) begin errors++; $display("FAIL rm_done: got %b expected 1", m0_ready); end
        $display("txn after reset: m0 addr=%h", s_addr);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_err_clear();
        err_clear = 1'b1;
        m1_valid = 1'b1; m1_addr = 32'h0500_0020; m1_wstrb = 4'h0;
        #1;
        repeat (9) @(negedge clk);
        #1;
        checks++; if (m1_ready !== 1'b1 || m1_rdata !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL ec_resp: got %b/%h expected 1/ffffffff", m1_ready, m1_rdata);
        end
        $display("txn timeout: m1 addr=%h rdata=%h", m1_addr, m1_rdata);
        @(negedge clk);
        m1_valid = 1'b0;
        #1;
        checks++; if (err_timeout !== 1'b1 || err_addr !== 32'h0500_0020) begin
            errors++; $display("FAIL ec_set_wins: got %b/%h expected 1/05000020", err_timeout, err_addr);
        end
        @(negedge clk);
        err_clear = 1'b0;
        #1;
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL ec_clear: got %b expected 0", err_timeout); end
        idle_inputs();
        @(negedge clk);
    endtask

    // Granted master drops valid before ready: no response, no error and
    // round-robin pointer unchanged.
    task automatic test_violation();
        m0_valid = 1'b1; m0_addr = 32'h0300_0004; m0_wstrb = 4'hF;
        #1;
        @(negedge clk);
        s_ready = 1'b1;
        #1;
        checks++; if (m0_ready !== 1'b1) begin errors++; $display("FAIL pv_m0: got %b expected 1", m0_ready); end
        @(negedge clk);
        idle_inputs();
        m1_valid = 1'b1; m1_addr = 32'h0300_0008; m1_wstrb = 4'hF;
        #1;
        @(negedge clk); #1;
        checks++; if (s_valid !== 1'b1 || grant !== 1'b1) begin errors++; $display("FAIL pv_busy: got %b/%b expected 1/1", s_valid, grant); end
        @(negedge clk);
        m1_valid = 1'b0;
        #1;
        checks++; if (s_valid !== 1'b0 || m1_ready !== 1'b0) begin errors++; $display("FAIL pv_drop: got %b/%b expected 0/0", s_valid, m1_ready); end
        @(negedge clk);
        m0_valid = 1'b1; m1_valid = 1'b1;
        #1;
        checks++; if (err_timeout !== 1'b0 || s_valid !== 1'b0) begin errors++; $display("FAIL pv_idle: got %b/%b expected 0/0", err_timeout, s_valid); end
        @(negedge clk); #1;
        checks++; if (grant !== 1'b1) begin errors++; $display("FAIL pv_last_grant: got %b expected 1", grant); end
        s_ready = 1'b1;
        #1;
        checks++; if (m1_ready !== 1'b1 || m0_ready !== 1'b0) begin errors++; $display("FAIL pv_serve: got %b%b expected 10", m1_ready, m0_ready); end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
    endtask

    // Randomized masters and a slave with 0..5 cycles of wait state.
    // Model: when free, serve the single requester, or on a tie the one
    // not served last; the served master then sees exactly its own request
    // on the slave port until the slave answers.
    task automatic test_random();
        bit          mv[2];
        logic [31:0] ma[2], mw[2];
        logic [3:0]  ms[2];
        int          cool[2];
        bit          busy;
        int          g, last, lat, scnt, ntx;
        logic        exp_r0, exp_r1;
        resetn = 1'b0;
        idle_inputs();
        @(negedge clk);
        resetn = 1'b1;
        busy = 0; g = 0; last = 1; scnt = 0; ntx = 0;
        lat = $urandom_range(0, 5);
        for (int i = 0; i < 2; i++) begin mv[i] = 0; cool[i] = 0; ma[i] = '0; mw[i] = '0; ms[i] = '0; end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!mv[i]) begin
                    if (cool[i] > 0) cool[i]--;
                    else if ($urandom_range(0, 1) == 1) begin
                        mv[i] = 1; ma[i] = $urandom; mw[i] = $urandom; ms[i] = 4'($urandom_range(0, 15));
                    end
                end
            end
            m0_valid = mv[0]; m0_addr = ma[0]; m0_wdata = mw[0]; m0_wstrb = ms[0];
            m1_valid = mv[1]; m1_addr = ma[1]; m1_wdata = mw[1]; m1_wstrb = ms[1];
            s_ready = (scnt >= lat); s_rdata = $urandom;
            #1;
            if (!busy) begin
                checks++; if (s_valid !== 1'b0 || m0_ready !== 1'b0 || m1_ready !== 1'b0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
                    errors++; $display("FAIL rnd_idle cyc %0d: got s_valid=%b ready=%b%b rdata=%h/%h expected all 0", cyc, s_valid, m0_ready, m1_ready, m0_rdata, m1_rdata);
                end
                if (mv[0] || mv[1]) begin
                    g = (mv[0] && mv[1]) ? 1 - last : (mv[0] ? 0 : 1);
                    busy = 1;
                end
            end else begin
                exp_r0 = s_ready && (g == 0);
                exp_r1 = s_ready && (g == 1);
                checks++; if (grant !== g[0] || s_valid !== 1'b1) begin
                    errors++; $display("FAIL rnd_grant cyc %0d: got grant=%b s_valid=%b expected %0d/1", cyc, grant, s_valid, g);
                end
                checks++; if (s_addr !== ma[g] || s_wdata !== mw[g] || s_wstrb !== ms[g]) begin
                    errors++; $display("FAIL rnd_payload cyc %0d: got %h/%h/%h expected %h/%h/%h", cyc, s_addr, s_wdata, s_wstrb, ma[g], mw[g], ms[g]);
                end
                checks++; if (m0_ready !== exp_r0 || m1_ready !== exp_r1) begin
                    errors++; $display("FAIL rnd_ready cyc %0d: got %b%b expected %b%b", cyc, m0_ready, m1_ready, exp_r0, exp_r1);
                end
                checks++; if ((g == 0 ? m1_rdata : m0_rdata) !== 32'h0 || (s_ready && (g == 0 ? m0_rdata : m1_rdata) !== s_rdata)) begin
                    errors++; $display("FAIL rnd_rdata cyc %0d: got %h/%h expected granted m%0d=%h other 0", cyc, m0_rdata, m1_rdata, g, s_rdata);
                end
                if (s_ready) begin
                    ntx++;
                    $display("txn rnd %0d: m%0d addr=%h wstrb=%h rdata=%h", ntx, g, ma[g], ms[g], s_rdata);
                    mv[g] = 0; cool[g] = $urandom_range(0, 2);
                    last = g; busy = 0; scnt = 0; lat = $urandom_range(0, 5);
                end else begin
                    scnt++;
                end
            end
            @(negedge clk);
        end
        checks++; if (ntx < 100) begin errors++; $display("FAIL rnd_progress: got %0d transactions expected at least 100", ntx); end
        idle_inputs();
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_tie();
        test_write();
        test_read();
        test_timeout();
        test_reset_mid();
        test_err_clear();
        test_violation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iomem_arbiter.md
IOMEM_ARBITER -- requirements
Module: iomem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 255, number of BUSY cycles without s_ready before the transaction is force-completed (range 1..65535).
REQ-002 Parameter ERR_RDATA, 32'hFFFF_FFFF, read data returned to a master on timeout.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  single clock; all state on its rising edge.
REQ-005 resetn  input  1  asynchronous active-low reset.
REQ-006 m0_valid/m0_ready/m0_wstrb/m0_addr/m0_wdata/m0_rdata  in/out/in/in/in/out  1/1/4/32/32/32  master 0 (CPU) iomem port.
REQ-007 m1_valid/m1_ready/m1_wstrb/m1_addr/m1_wdata/m1_rdata  in/out/in/in/in/out  1/1/4/32/32/32  master 1 (accelerator) iomem port.
REQ-008 s_valid/s_ready/s_wstrb/s_addr/s_wdata/s_rdata  out/in/out/out/out/in  1/1/4/32/32/32  shared iomem slave port (GPIO and peripheral decode).
REQ-009 err_clear  input  1  clears err_timeout when high for one cycle.
REQ-010 err_timeout  output  1  sticky timeout flag.
REQ-011 err_addr  output  32  address of the most recent timed-out transaction.
REQ-012 grant  output  1  index of the master currently or last granted.

Function
REQ-013 Protocol: valid held high until one-cycle ready pulse; wstrb==0 means read; master drops valid on the edge that samples ready.
REQ-014 States: IDLE, BUSY; reset state IDLE.
REQ-015 IDLE, no valid: stay IDLE, s_valid=0, m*_ready=0.
REQ-016 IDLE, one valid: register grant to that master, go BUSY next edge.
REQ-017 IDLE, both valid: grant the master not equal to last_grant (round-robin); last_grant resets to 1, so m0 wins the first tie.
REQ-018 BUSY: s_valid/s_wstrb/s_addr/s_wdata combinationally follow the granted master; non-granted master sees ready=0.
REQ-019 BUSY and s_ready=1: granted m_ready=1 and m_rdata=s_rdata in the same cycle (zero added response latency); last_grant<=grant; go IDLE.
REQ-020 Minimum latency: valid at cycle 0 in IDLE, s_valid at cycle 1, m_ready at cycle 1 earliest (if slave is combinational), cycle 2 with registered-ready slave.
REQ-021 Timeout counter (16 bit) clears on BUSY entry, increments each BUSY cycle without s_ready.
REQ-022 Counter reaching TIMEOUT_CYCLES: granted m_ready=1, m_rdata=ERR_RDATA, err_timeout<=1, err_addr<=granted addr, s_valid=0 that cycle, go IDLE.
REQ-023 s_ready while IDLE (late slave response) SHALL be ignored.
REQ-024 Granted valid dropping in BUSY without ready (protocol violation): go IDLE, no ready, no error, last_grant unchanged.
REQ-025 err_clear and a new timeout in the same cycle: set wins.
REQ-026 Non-granted m_rdata SHALL be 0.

Reset
REQ-027 Reset asserted mid-transaction SHALL immediately force state IDLE, s_valid=0, m0_ready=m1_ready=0.
REQ-028 Reset values: grant=0, last_grant=1, counter=0, err_timeout=0, err_addr=0.
REQ-029 First arbitration decision SHALL occur on the first rising edge after resetn deasserts.

Structure
REQ-030 Package iomem_arb_pkg SHALL hold the state encoding, default TIMEOUT_CYCLES and ERR_RDATA constants.
REQ-031 Sub-module iomem_timeout_ctr (clear, enable, terminal-count output) SHALL implement REQ-021.
REQ-032 Target size 120-400 RTL lines; no memories.

Verification
REQ-033 m0 write addr 0x0300_0000 wdata 0x0000_00A5 wstrb 4'hF, slave ready after 1 cycle -> s_addr=0x0300_0000, m0_ready one cycle, m1_ready=0.
REQ-034 m0 and m1 valid same cycle after reset -> m0 served first, m1 served next; repeat tie -> m1 then m0 alternation.
REQ-035 m1 read 0x0300_0000, slave returns 0x1234_5678 -> m1_rdata=0x1234_5678 coincident with m1_ready.
REQ-036 TIMEOUT_CYCLES=8, slave never ready, m0 read 0x0400_0010 -> m0_ready after 8 BUSY cycles, m0_rdata=0xFFFF_FFFF, err_timeout=1, err_addr=0x0400_0010; late s_ready ignored.
REQ-037 resetn pulsed low while BUSY -> s_valid and all ready outputs 0 immediately, err state cleared, next request arbitrated normally.
REQ-038 err_timeout=1 and err_clear pulsed with no new timeout -> err_timeout=0 next cycle.
